// File: rtl/tick_rate_pkg.sv
// Shared selection encoding and period multipliers for tick_rate_ctrl.
package tick_rate_pkg;

  localparam logic [1:0] SEL_0S5 = 2'b00;
  localparam logic [1:0] SEL_1S  = 2'b01;
  localparam logic [1:0] SEL_2S  = 2'b10;
  localparam logic [1:0] SEL_6S  = 2'b11;

  localparam int MAX_MULT = 12;

  // Period length in units of half a second for each selection code.
  function automatic int sel_mult(input logic [1:0] sel);
    case (sel)
      SEL_0S5: return 1;
      SEL_1S:  return 2;
      SEL_2S:  return 4;
      default: return MAX_MULT;
    endcase
  endfunction

endpackage

// File: rtl/sel_debouncer.sv
// Two-flop synchronizer plus stable-count filter for the 2-bit rate selection switches.
module sel_debouncer
  import tick_rate_pkg::*;
#(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] raw,
  output logic [1:0] req
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [CNT_W-1:0] stable_cnt;
  logic             restart;

  // A change arriving at sync_p1 on this edge, or agreement with the current
  // request, means there is no run of identical differing samples to extend.
  assign restart = (sync_p0 != sync_p1) || (sync_p1 == req);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= SEL_0S5;
      sync_p1    <= SEL_0S5;
      stable_cnt <= '0;
      req        <= SEL_0S5;
    end else begin
      // stage p0 -> p1: metastability settling
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (restart) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        req        <= sync_p1;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_rate_ctrl.sv
// Selectable-period tick generator; TICK_RATE_SQUARE_EN adds the sq_out LED square wave.
module tick_rate_ctrl
  import tick_rate_pkg::*;
#(
  parameter int HALF_SEC_CYCLES = 25_000_000,
  parameter int DEB_CYCLES      = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel1,
  input  logic       sel0,
  input  logic       run,
  output logic       tick,
  output logic [1:0] sel_active,
  output logic       pending
`ifdef TICK_RATE_SQUARE_EN
  ,
  output logic       sq_out
`endif
);

  localparam int CNT_W = $clog2(MAX_MULT * HALF_SEC_CYCLES);

  logic [1:0]       deb_req;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] limit_m1;
  logic [1:0]       sel_next;
  logic             differs;
  logic             wrap;

  sel_debouncer #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk(clk),
    .rst(rst),
    .raw({sel1, sel0}),
    .req(deb_req)
  );

  assign limit_m1 = CNT_W'(HALF_SEC_CYCLES * sel_mult(sel_active) - 1);
  assign differs  = (deb_req != sel_active);
  assign wrap     = run && (period_cnt == limit_m1);

  // Selection changes only at a period boundary while running, or at once
  // while paused (restarting the period from zero).
  always_comb begin
    sel_next = sel_active;
    cnt_next = period_cnt;
    if (run) begin
      if (wrap) begin
        cnt_next = '0;
        if (differs) sel_next = deb_req;
      end else begin
        cnt_next = period_cnt + 1'b1;
      end
    end else if (differs) begin
      sel_next = deb_req;
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      sel_active <= SEL_0S5;
      tick       <= 1'b0;
      pending    <= 1'b0;
    end else begin
      // stage: registered outputs
      period_cnt <= cnt_next;
      sel_active <= sel_next;
      tick       <= wrap;
      pending    <= (deb_req != sel_next);
    end
  end

`ifdef TICK_RATE_SQUARE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_out <= 1'b0;
    end else if (wrap) begin
      sq_out <= ~sq_out;
    end
  end
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Scoreboard bench for tick_rate_ctrl (HALF_SEC_CYCLES=4, DEB_CYCLES=3).
module tb_tick_rate_ctrl;

  localparam int HALF = 4;
  localparam int DEB  = 3;

  logic       clk;
  logic       rst;
  logic       sel1;
  logic       sel0;
  logic       run;
  logic       tick;
  logic [1:0] sel_active;
  logic       pending;
`ifdef TICK_RATE_SQUARE_EN
  logic       sq_out;
`endif

  tick_rate_ctrl #(
    .HALF_SEC_CYCLES(HALF),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel1(sel1),
    .sel0(sel0),
    .run(run),
    .tick(tick),
    .sel_active(sel_active),
    .pending(pending)
`ifdef TICK_RATE_SQUARE_EN
    ,
    .sq_out(sq_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, stepped on each rising edge.
  int         cyc = 0;
  logic [1:0] hist [4];
  logic [1:0] m_req;
  logic [1:0] m_sel;
  logic [1:0] m_nsel;
  logic       m_pend;
  logic       m_sq;
  int         m_cnt;
  int         m_lim;
  int         exp_q [$];

  function automatic int mult(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 12;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = 2'b00;
      m_req  = 2'b00;
      m_sel  = 2'b00;
      m_pend = 1'b0;
      m_sq   = 1'b0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      m_lim  = HALF * mult(m_sel);
      m_nsel = m_sel;
      if (run) begin
        if (m_cnt == m_lim - 1) begin
          m_cnt = 0;
          exp_q.push_back(cyc);
          m_sq = ~m_sq;
          if (m_req != m_sel) m_nsel = m_req;
        end else begin
          m_cnt++;
        end
      end else if (m_req != m_sel) begin
        m_nsel = m_req;
        m_cnt  = 0;
      end
      m_sel  = m_nsel;
      m_pend = (m_req != m_sel);
      // Request follows a switch value seen on DEB+1 consecutive raw samples.
      if (hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3]) m_req = hist[0];
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {sel1, sel0};
    end
  end

  // Monitor: tick against the scoreboard, plus interval rules per phase.
  int   iv_mode = 0;
  int   last_tick = -1;
  logic exp_t;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_t = (exp_q.size() > 0) && (exp_q[0] == cyc);
      if (exp_t) void'(exp_q.pop_front());
      chk("tick", int'(tick), int'(exp_t));
      chk("sel_active", int'(sel_active), int'(m_sel));
      chk("pending", int'(pending), int'(m_pend));
`ifdef TICK_RATE_SQUARE_EN
      chk("sq_out", int'(sq_out), int'(m_sq));
`endif
      if (tick) begin
        if (last_tick >= 0) begin
          if (iv_mode == 1) chk("interval_4", cyc - last_tick, 4);
          if (iv_mode == 2) chk("interval_4_or_48",
                                int'((cyc - last_tick == 4) || (cyc - last_tick == 48)), 1);
          if (iv_mode == 3) chk("interval_48", cyc - last_tick, 48);
        end
        last_tick = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int   k;
  logic pend_seen;

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < budget);
    if (!tick) n = -1;
  endtask

  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    sel1 = 1'b0;
    sel0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tick", int'(tick), 0);
    chk("reset_sel", int'(sel_active), 0);
    chk("reset_pending", int'(pending), 0);

    // 0.5 s period, free running
    rst = 1'b0;
    run = 1'b1;
    iv_mode = 1;
    wait_tick(20, k);
    chk("first_tick_lat", k, 4);
    repeat (16) @(negedge clk);

    // Two-cycle glitch on sel0 must be filtered out
    sel0 = 1'b1;
    repeat (2) @(negedge clk);
    sel0 = 1'b0;
    pend_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pending) pend_seen = 1'b1;
    end
    chk("glitch_pending", int'(pend_seen), 0);

    // 00 -> 11 one cycle after a tick, applied at the following wrap
    wait_tick(20, k);
    @(negedge clk);
    iv_mode = 2;
    sel1 = 1'b1;
    sel0 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pending && k < 20);
    chk("pending_lat", k, 6);
    k = 0;
    while (sel_active != 2'b11 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("sel_now_6s", int'(sel_active), 3);
    @(negedge clk);
    iv_mode = 3;
    wait_tick(60, k);
    chk("first_48_tick", k, 47);
    wait_tick(60, k);
    chk("second_48_tick", k, 48);

    // Paused change applies immediately and clears the counter
    iv_mode = 0;
    run  = 1'b0;
    sel1 = 1'b1;
    sel0 = 1'b0;
    repeat (12) @(negedge clk);
    chk("pause_sel", int'(sel_active), 2);
    chk("pause_pending", int'(pending), 0);
    run = 1'b1;
    // tick lands in the 17th cycle counting the one run rose in
    wait_tick(40, k);
    chk("pause_first_tick", k, 16);

    // Reset two cycles ahead of the next tick drops it
    repeat (14) @(negedge clk);
    rst  = 1'b1;
    sel1 = 1'b0;
    sel0 = 1'b0;
    @(negedge clk);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_sel", int'(sel_active), 0);
    chk("midrst_pending", int'(pending), 0);
    rst = 1'b0;
    wait_tick(20, k);
    chk("post_rst_tick", k, 4);

    run = 1'b0;
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
